// File: rtl/elevator_ctrl_n.sv
// N-floor elevator controller: latches floor calls and serves them with SCAN ordering,
// with internal travel/door timing and door-obstruction / overweight alert handling.
module elevator_ctrl_n #(
  parameter int NUM_FLOORS  = 8,
  parameter int FLOOR_W     = 3,
  parameter int MOVE_CYCLES = 8,
  parameter int DOOR_CYCLES = 16,
  parameter int TIMER_W     = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] call_req,
  input  logic                  sensor_puerta,
  input  logic                  sensor_sobrepeso,
  output logic [FLOOR_W-1:0]    current_floor,
  output logic [NUM_FLOORS-1:0] pending,
  output logic [2:0]            state,
  output logic                  arrive,
  output logic                  subiendo_LED,
  output logic                  bajando_LED,
  output logic                  freno_act_LED,
  output logic                  motor_act_LED,
  output logic                  puerta_abierta_LED,
  output logic                  puerta_cerrada_LED,
  output logic                  sensor_puerta_LED,
  output logic                  sensor_sobrepeso_LED
);

  typedef enum logic [2:0] {
    REPOSO         = 3'd0,
    MOVIMIENTO     = 3'd1,
    DETENER        = 3'd2,
    PUERTA_ABIERTA = 3'd3,
    ALERTA         = 3'd4,
    CIERRA_PUERTA  = 3'd5
  } state_e;

  localparam logic [TIMER_W-1:0]    MOVE_LAST  = TIMER_W'(MOVE_CYCLES - 1);
  localparam logic [TIMER_W-1:0]    DOOR_LAST  = TIMER_W'(DOOR_CYCLES - 1);
  localparam logic [TIMER_W-1:0]    CNT_ZERO   = TIMER_W'(0);
  localparam logic [TIMER_W-1:0]    CNT_ONE    = TIMER_W'(1);
  localparam logic [FLOOR_W-1:0]    TOP_FLOOR  = FLOOR_W'(NUM_FLOORS - 1);
  localparam logic [FLOOR_W-1:0]    FLOOR_ZERO = FLOOR_W'(0);
  localparam logic [FLOOR_W-1:0]    FLOOR_ONE  = FLOOR_W'(1);
  localparam logic [NUM_FLOORS-1:0] ONE_HOT0   = NUM_FLOORS'(1);

  function automatic logic any_above(input logic [NUM_FLOORS-1:0] pend,
                                     input logic [FLOOR_W-1:0]    flr);
    logic r;
    r = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      r = r | (pend[i] & (i > int'(flr)));
    end
    return r;
  endfunction

  function automatic logic any_below(input logic [NUM_FLOORS-1:0] pend,
                                     input logic [FLOOR_W-1:0]    flr);
    logic r;
    r = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      r = r | (pend[i] & (i < int'(flr)));
    end
    return r;
  endfunction

  state_e                  state_q, state_d;
  logic [FLOOR_W-1:0]      floor_q, floor_d;
  logic [NUM_FLOORS-1:0]   pending_q, pending_d;
  logic [TIMER_W-1:0]      cnt_q, cnt_d;
  logic                    dir_q, dir_d;
  logic                    arrive_q;
  logic                    sub_led_q, baj_led_q, freno_led_q, motor_led_q;
  logic                    abierta_led_q, cerrada_led_q, sp_led_q, so_led_q;

  logic [NUM_FLOORS-1:0]   clear_mask_s;
  logic [FLOOR_W-1:0]      next_floor_s;
  logic                    here_s, above_s, below_s;
  logic                    next_here_s, next_above_s, next_below_s;
  logic                    sensor_any_s, call_here_s, door_open_d_s;

  // Scheduling and next-state decision for the car.
  always_comb begin
    sensor_any_s = sensor_puerta | sensor_sobrepeso;
    call_here_s  = call_req[floor_q];
    here_s       = pending_q[floor_q];
    above_s      = any_above(pending_q, floor_q);
    below_s      = any_below(pending_q, floor_q);

    if (dir_q) begin
      next_floor_s = (floor_q == TOP_FLOOR) ? floor_q : floor_q + FLOOR_ONE;
    end else begin
      next_floor_s = (floor_q == FLOOR_ZERO) ? floor_q : floor_q - FLOOR_ONE;
    end
    next_here_s  = pending_q[next_floor_s];
    next_above_s = any_above(pending_q, next_floor_s);
    next_below_s = any_below(pending_q, next_floor_s);

    // The served floor is cleared on arrival and whenever a re-call hits an open door.
    if ((state_q == DETENER) || ((state_q == PUERTA_ABIERTA) && call_here_s)) begin
      clear_mask_s = ONE_HOT0 << floor_q;
    end else begin
      clear_mask_s = {NUM_FLOORS{1'b0}};
    end
    pending_d = (pending_q | call_req) & ~clear_mask_s;

    state_d = state_q;
    floor_d = floor_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;

    case (state_q)
      REPOSO: begin
        if (here_s) begin
          state_d = DETENER;
        end else if (above_s) begin
          dir_d   = 1'b1;
          cnt_d   = CNT_ZERO;
          state_d = MOVIMIENTO;
        end else if (below_s) begin
          dir_d   = 1'b0;
          cnt_d   = CNT_ZERO;
          state_d = MOVIMIENTO;
        end else begin
          state_d = REPOSO;
        end
      end
      MOVIMIENTO: begin
        if (cnt_q == MOVE_LAST) begin
          floor_d = next_floor_s;
          cnt_d   = CNT_ZERO;
          if (next_here_s) begin
            state_d = DETENER;
          end else if (dir_q ? next_above_s : next_below_s) begin
            state_d = MOVIMIENTO;
          end else if (dir_q ? next_below_s : next_above_s) begin
            dir_d   = ~dir_q;
            state_d = MOVIMIENTO;
          end else begin
            state_d = REPOSO;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      DETENER: begin
        cnt_d   = DOOR_LAST;
        state_d = PUERTA_ABIERTA;
      end
      PUERTA_ABIERTA: begin
        if (sensor_any_s) begin
          state_d = ALERTA;
        end else if (call_here_s) begin
          cnt_d = DOOR_LAST;
        end else if (cnt_q == CNT_ZERO) begin
          state_d = CIERRA_PUERTA;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ALERTA: begin
        if (sensor_any_s) begin
          state_d = ALERTA;
        end else begin
          cnt_d   = DOOR_LAST;
          state_d = PUERTA_ABIERTA;
        end
      end
      CIERRA_PUERTA: begin
        // A call for this floor caught while closing goes back through REPOSO to reopen.
        if (here_s || call_here_s) begin
          state_d = REPOSO;
        end else if (above_s) begin
          dir_d   = 1'b1;
          cnt_d   = CNT_ZERO;
          state_d = MOVIMIENTO;
        end else if (below_s) begin
          dir_d   = 1'b0;
          cnt_d   = CNT_ZERO;
          state_d = MOVIMIENTO;
        end else begin
          state_d = REPOSO;
        end
      end
      default: begin
        state_d = REPOSO;
      end
    endcase

    door_open_d_s = (state_d == PUERTA_ABIERTA) || (state_d == ALERTA);
  end

  // State, position, call and indicator registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= REPOSO;
      floor_q       <= FLOOR_ZERO;
      pending_q     <= {NUM_FLOORS{1'b0}};
      cnt_q         <= CNT_ZERO;
      dir_q         <= 1'b1;
      arrive_q      <= 1'b0;
      sub_led_q     <= 1'b0;
      baj_led_q     <= 1'b0;
      freno_led_q   <= 1'b1;
      motor_led_q   <= 1'b0;
      abierta_led_q <= 1'b0;
      cerrada_led_q <= 1'b1;
      sp_led_q      <= 1'b0;
      so_led_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      floor_q       <= floor_d;
      pending_q     <= pending_d;
      cnt_q         <= cnt_d;
      dir_q         <= dir_d;
      arrive_q      <= (state_q == DETENER);
      sub_led_q     <= (state_d == MOVIMIENTO) & dir_d;
      baj_led_q     <= (state_d == MOVIMIENTO) & ~dir_d;
      freno_led_q   <= (state_d != MOVIMIENTO);
      motor_led_q   <= (state_d == MOVIMIENTO);
      abierta_led_q <= door_open_d_s;
      cerrada_led_q <= ~door_open_d_s;
      sp_led_q      <= (state_d == ALERTA) & sensor_puerta;
      so_led_q      <= (state_d == ALERTA) & sensor_sobrepeso;
    end
  end

  assign state                = state_q;
  assign current_floor        = floor_q;
  assign pending              = pending_q;
  assign arrive               = arrive_q;
  assign subiendo_LED         = sub_led_q;
  assign bajando_LED          = baj_led_q;
  assign freno_act_LED        = freno_led_q;
  assign motor_act_LED        = motor_led_q;
  assign puerta_abierta_LED   = abierta_led_q;
  assign puerta_cerrada_LED   = cerrada_led_q;
  assign sensor_puerta_LED    = sp_led_q;
  assign sensor_sobrepeso_LED = so_led_q;

endmodule

// File: tb/tb_elevator_ctrl_n.sv
// Directed bench for elevator_ctrl_n (8 floors, 4-cycle floor travel, 16-cycle door dwell).
module tb_elevator_ctrl_n;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] call_req = 8'h00;
  logic       sensor_puerta = 1'b0;
  logic       sensor_sobrepeso = 1'b0;

  logic [2:0] current_floor;
  logic [7:0] pending;
  logic [2:0] state;
  logic       arrive;
  logic       subiendo_LED, bajando_LED, freno_act_LED, motor_act_LED;
  logic       puerta_abierta_LED, puerta_cerrada_LED;
  logic       sensor_puerta_LED, sensor_sobrepeso_LED;

  int n_cmp = 0;
  int n_bad = 0;

  elevator_ctrl_n #(
    .NUM_FLOORS(8), .FLOOR_W(3), .MOVE_CYCLES(4), .DOOR_CYCLES(16), .TIMER_W(8)
  ) dut (
    .clk(clk), .reset(reset), .call_req(call_req),
    .sensor_puerta(sensor_puerta), .sensor_sobrepeso(sensor_sobrepeso),
    .current_floor(current_floor), .pending(pending), .state(state), .arrive(arrive),
    .subiendo_LED(subiendo_LED), .bajando_LED(bajando_LED),
    .freno_act_LED(freno_act_LED), .motor_act_LED(motor_act_LED),
    .puerta_abierta_LED(puerta_abierta_LED), .puerta_cerrada_LED(puerta_cerrada_LED),
    .sensor_puerta_LED(sensor_puerta_LED), .sensor_sobrepeso_LED(sensor_sobrepeso_LED)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_call(input int f);
    call_req    = 8'h00;
    call_req[f] = 1'b1;
    tick(1);
    call_req    = 8'h00;
  endtask

  task automatic wait_state(input string tag, input logic [2:0] s, input int budget);
    int k;
    k = 0;
    while ((state !== s) && (k < budget)) begin
      tick(1);
      k++;
    end
    check_eq(tag, {29'd0, state}, {29'd0, s});
  endtask

  // Counts consecutive sampled door-open cycles (and arrive pulses seen in them).
  task automatic count_open(output int n, output int arr);
    n   = 0;
    arr = 0;
    while ((state === 3'd3) && (n < 200)) begin
      n++;
      arr += int'(arrive);
      tick(1);
    end
  endtask

  initial begin
    int bad;
    int n;
    int arr;
    int k;

    // Reset state
    tick(3);
    check_eq("rst_state", state, 3'd0);
    check_eq("rst_floor", current_floor, 3'd0);
    check_eq("rst_pending", pending, 8'h00);
    check_eq("rst_freno", freno_act_LED, 1'b1);
    check_eq("rst_cerrada", puerta_cerrada_LED, 1'b1);
    check_eq("rst_motor", motor_act_LED, 1'b0);
    check_eq("rst_arrive", arrive, 1'b0);
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      if ((state !== 3'd0) || (current_floor !== 3'd0) || (pending !== 8'h00) ||
          (motor_act_LED !== 1'b0) || (freno_act_LED !== 1'b1)) bad++;
    end
    check_eq("idle_hold", bad, 0);

    // Single call to floor 3 from floor 0
    pulse_call(3);
    check_eq("t2_pend_set", pending, 8'h08);
    check_eq("t2_still_idle", state, 3'd0);
    tick(1);
    check_eq("t2_move", state, 3'd1);
    check_eq("t2_sub_led", subiendo_LED, 1'b1);
    check_eq("t2_motor", motor_act_LED, 1'b1);
    check_eq("t2_freno", freno_act_LED, 1'b0);
    tick(3);
    check_eq("t2_floor0_late", current_floor, 3'd0);
    tick(1);
    check_eq("t2_floor1", current_floor, 3'd1);
    tick(4);
    check_eq("t2_floor2", current_floor, 3'd2);
    tick(4);
    check_eq("t2_floor3", current_floor, 3'd3);
    check_eq("t2_detener", state, 3'd2);
    tick(1);
    check_eq("t2_door_state", state, 3'd3);
    check_eq("t2_arrive", arrive, 1'b1);
    check_eq("t2_pend_clr", pending, 8'h00);
    check_eq("t2_abierta", puerta_abierta_LED, 1'b1);
    check_eq("t2_cerrada", puerta_cerrada_LED, 1'b0);
    count_open(n, arr);
    check_eq("t2_dwell", n, 16);
    check_eq("t2_arrive_cnt", arr, 1);
    check_eq("t2_cierra", state, 3'd5);
    tick(1);
    check_eq("t2_reposo", state, 3'd0);
    check_eq("t2_cerrada_end", puerta_cerrada_LED, 1'b1);

    // SCAN: up from 2 serving 5, then reverse to 1
    pulse_call(2);
    wait_state("t3_stop2", 3'd2, 40);
    check_eq("t3_floor2", current_floor, 3'd2);
    wait_state("t3_idle2", 3'd0, 60);
    pulse_call(5);
    tick(1);
    check_eq("t3_move_up", state, 3'd1);
    check_eq("t3_sub_led", subiendo_LED, 1'b1);
    pulse_call(1);
    check_eq("t3_pend_both", pending, 8'h22);
    wait_state("t3_stop5", 3'd2, 40);
    check_eq("t3_floor5", current_floor, 3'd5);
    tick(1);
    check_eq("t3_pend_after5", pending, 8'h02);
    wait_state("t3_close5", 3'd5, 40);
    tick(1);
    check_eq("t3_move_dn", state, 3'd1);
    check_eq("t3_baj_led", bajando_LED, 1'b1);
    check_eq("t3_sub_off", subiendo_LED, 1'b0);
    wait_state("t3_stop1", 3'd2, 40);
    check_eq("t3_floor1", current_floor, 3'd1);
    tick(1);
    check_eq("t3_pend_empty", pending, 8'h00);
    wait_state("t3_idle1", 3'd0, 40);

    // Overweight alert while door open
    pulse_call(1);
    tick(1);
    check_eq("t4_detener", state, 3'd2);
    tick(1);
    check_eq("t4_open", state, 3'd3);
    tick(4);
    sensor_sobrepeso = 1'b1;
    tick(1);
    check_eq("t4_alerta", state, 3'd4);
    check_eq("t4_so_led", sensor_sobrepeso_LED, 1'b1);
    check_eq("t4_sp_led", sensor_puerta_LED, 1'b0);
    check_eq("t4_door_open", puerta_abierta_LED, 1'b1);
    tick(9);
    check_eq("t4_alerta_hold", state, 3'd4);
    check_eq("t4_so_led_hold", sensor_sobrepeso_LED, 1'b1);
    sensor_sobrepeso = 1'b0;
    tick(1);
    check_eq("t4_reopen", state, 3'd3);
    check_eq("t4_so_led_clr", sensor_sobrepeso_LED, 1'b0);
    count_open(n, arr);
    check_eq("t4_dwell", n, 16);
    check_eq("t4_no_arrive", arr, 0);
    check_eq("t4_cierra", state, 3'd5);
    wait_state("t4_idle", 3'd0, 5);

    // Re-call at the open door when counter is 3
    pulse_call(1);
    tick(2);
    check_eq("t5_open", state, 3'd3);
    tick(12);
    check_eq("t5_still_open", state, 3'd3);
    call_req[1] = 1'b1;
    tick(1);
    call_req = 8'h00;
    check_eq("t5_open_restart", state, 3'd3);
    check_eq("t5_pend_not_set", pending, 8'h00);
    count_open(n, arr);
    check_eq("t5_dwell", n, 16);
    check_eq("t5_no_arrive", arr, 0);
    wait_state("t5_idle", 3'd0, 5);

    // Reset mid-travel between floors 4 and 5
    pulse_call(7);
    k = 0;
    while ((current_floor !== 3'd4) && (k < 100)) begin
      tick(1);
      k++;
    end
    check_eq("t6_reach4", current_floor, 3'd4);
    tick(2);
    check_eq("t6_moving", state, 3'd1);
    reset = 1'b1;
    #1;
    check_eq("t6_state", state, 3'd0);
    check_eq("t6_floor", current_floor, 3'd0);
    check_eq("t6_pending", pending, 8'h00);
    check_eq("t6_motor", motor_act_LED, 1'b0);
    check_eq("t6_freno", freno_act_LED, 1'b1);
    tick(2);
    reset = 1'b0;
    tick(1);
    check_eq("t6_idle_after", state, 3'd0);

    // Call at floor 0 while idle at floor 0
    pulse_call(0);
    check_eq("t7_pend0", pending, 8'h01);
    check_eq("t7_idle", state, 3'd0);
    tick(1);
    check_eq("t7_detener", state, 3'd2);
    check_eq("t7_no_motor", motor_act_LED, 1'b0);
    tick(1);
    check_eq("t7_open", state, 3'd3);
    check_eq("t7_arrive", arrive, 1'b1);
    check_eq("t7_floor", current_floor, 3'd0);
    count_open(n, arr);
    check_eq("t7_dwell", n, 16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
